// File: rtl/vu_pkg.sv
// rtl/vu_pkg.sv - level thresholds, level type and bar decode for the VU meter
package vu_pkg;

   localparam logic [14:0] TH1 = 15'd256;
   localparam logic [14:0] TH2 = 15'd1024;
   localparam logic [14:0] TH3 = 15'd4096;
   localparam logic [14:0] TH4 = 15'd16384;

   typedef logic [2:0] lvl_t;

   // Level 0..4 to a 4-LED thermometer; levels above 4 cannot occur
   function automatic logic [3:0] therm(input lvl_t lvl);
      case (lvl)
         3'd0:    therm = 4'b0000;
         3'd1:    therm = 4'b0001;
         3'd2:    therm = 4'b0011;
         3'd3:    therm = 4'b0111;
         default: therm = 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/vu_meter_if.sv
// rtl/vu_meter_if.sv - vld-qualified stereo sample stream into the VU meter
interface vu_meter_if;
   logic        vld;
   logic [15:0] lft_chnnl;
   logic [15:0] rght_chnnl;

   modport master (output vld, output lft_chnnl, output rght_chnnl);
   modport slave  (input  vld, input  lft_chnnl, input  rght_chnnl);
endinterface

// File: rtl/vu_chan.sv
// rtl/vu_chan.sv - one channel: magnitude, windowed peak, level, decaying display
module vu_chan
   import vu_pkg::*;
#(
   parameter int DECAY_WINS = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        vld,
   input  logic        win_last,
   input  logic        win_end,
   input  logic [15:0] smp,
   output logic [3:0]  bar
);

   localparam int DW = (DECAY_WINS > 1) ? $clog2(DECAY_WINS) : 1;
   localparam logic [DW-1:0] DCNT_MAX = DW'(DECAY_WINS - 1);

   logic [14:0]   pk_acc_q, pk_acc_d;
   logic [14:0]   pk_win_q, pk_win_d;
   lvl_t          disp_q, disp_d;
   logic [DW-1:0] dcnt_q, dcnt_d;

   logic [15:0] neg;
   logic [14:0] mag;
   logic [14:0] pk_max;
   lvl_t        new_lvl;

   always_comb begin
      neg = ~smp + 16'd1;
      // -32768 has no positive 16-bit counterpart, so it clamps to full scale
      if (smp[15])
         mag = (smp == 16'h8000) ? 15'h7fff : neg[14:0];
      else
         mag = smp[14:0];
      pk_max = (mag > pk_acc_q) ? mag : pk_acc_q;

      new_lvl = {2'b00, pk_win_q >= TH1} + {2'b00, pk_win_q >= TH2}
              + {2'b00, pk_win_q >= TH3} + {2'b00, pk_win_q >= TH4};

      pk_acc_d = pk_acc_q;
      pk_win_d = pk_win_q;
      if (vld) begin
         if (win_last) begin
            pk_win_d = pk_max;
            pk_acc_d = 15'd0;
         end else begin
            pk_acc_d = pk_max;
         end
      end

      disp_d = disp_q;
      dcnt_d = dcnt_q;
      if (win_end) begin
         if (new_lvl >= disp_q) begin
            disp_d = new_lvl;
            dcnt_d = '0;
         end else if (dcnt_q == DCNT_MAX) begin
            disp_d = disp_q - 3'd1;
            dcnt_d = '0;
         end else begin
            dcnt_d = dcnt_q + DW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pk_acc_q <= '0;
         pk_win_q <= '0;
         disp_q   <= '0;
         dcnt_q   <= '0;
      end else begin
         pk_acc_q <= pk_acc_d;
         pk_win_q <= pk_win_d;
         disp_q   <= disp_d;
         dcnt_q   <= dcnt_d;
      end
   end

   assign bar = therm(disp_q);

endmodule

// File: rtl/vu_meter.sv
// rtl/vu_meter.sv - stereo VU meter top: shared window counter and two channel bars
module vu_meter
   import vu_pkg::*;
#(
   parameter int WIN_LOG2   = 10,
   parameter int DECAY_WINS = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   vu_meter_if.slave        aud,
   output logic [7:0]       LED
);

   logic [WIN_LOG2-1:0] win_cnt_q, win_cnt_d;
   logic                win_end_q, win_end_d;
   logic                win_last;

   always_comb begin
      win_last  = aud.vld && (win_cnt_q == {WIN_LOG2{1'b1}});
      win_cnt_d = aud.vld ? win_cnt_q + WIN_LOG2'(1) : win_cnt_q;
      win_end_d = win_last;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_cnt_q <= '0;
         win_end_q <= 1'b0;
      end else begin
         win_cnt_q <= win_cnt_d;
         win_end_q <= win_end_d;
      end
   end

   vu_chan #(.DECAY_WINS(DECAY_WINS)) u_lft (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld      (aud.vld),
      .win_last (win_last),
      .win_end  (win_end_q),
      .smp      (aud.lft_chnnl),
      .bar      (LED[7:4])
   );

   vu_chan #(.DECAY_WINS(DECAY_WINS)) u_rght (
      .clk      (clk),
      .rst_n    (rst_n),
      .vld      (aud.vld),
      .win_last (win_last),
      .win_end  (win_end_q),
      .smp      (aud.rght_chnnl),
      .bar      (LED[3:0])
   );

endmodule
